// File: rtl/mult16s_share_sched_if.sv
// Request, issue and response signals between requester lanes, the scheduler and the shared multiplier.
// The master modport is the lanes plus multiplier side. The slave modport is the scheduler.
interface mult16s_share_sched_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic                en;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ-1:0]     req_ready;
  logic                mul_valid;
  logic [W-1:0]        mul_a;
  logic [W-1:0]        mul_b;
  logic [2*W-1:0]      mul_p;
  logic [NREQ-1:0]     rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [2*W-1:0]      rsp_data;
  logic                idle;
  logic [15:0]         issue_cnt;

  modport master (
    output en, req_valid, req_a, req_b, mul_p,
    input  req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, idle, issue_cnt
  );

  modport slave (
    input  en, req_valid, req_a, req_b, mul_p,
    output req_ready, mul_valid, mul_a, mul_b, rsp_valid, rsp_id, rsp_data, idle, issue_cnt
  );
endinterface

// File: rtl/mult16s_share_sched.sv
// Round-robin scheduler that shares one fixed-latency signed multiplier among NREQ requesters.
// A tag pipeline matched to LAT returns each product to its owner.
module mult16s_share_sched #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int LAT  = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  mult16s_share_sched_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_iss_id;
  logic            r_mul_valid;
  logic [W-1:0]    r_mul_a;
  logic [W-1:0]    r_mul_b;
  logic [LAT-1:0]  r_tag_v;
  logic [IDW-1:0]  r_tag_id [LAT];
  logic [NREQ-1:0] r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [2*W-1:0]  r_rsp_data;
  logic [15:0]     r_cnt;

  logic            w_acc;
  logic [IDW-1:0]  w_win;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_ptr_nxt;

  // The first valid requester at or after r_ptr, modulo NREQ, wins.
  always_comb begin : arb
    int unsigned idx;
    idx     = 0;
    w_acc   = 1'b0;
    w_win   = '0;
    w_grant = '0;
    if (bus.en) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = (32'(r_ptr) + k) % NREQ;
        if (!w_acc && bus.req_valid[idx[IDW-1:0]]) begin
          w_acc = 1'b1;
          w_win = idx[IDW-1:0];
        end
      end
    end
    if (w_acc) w_grant = NREQ'(1) << w_win;
  end

  assign w_ptr_nxt = (32'(w_win) == NREQ - 1) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_iss_id    <= '0;
      r_mul_valid <= 1'b0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_cnt       <= '0;
    end else begin
      r_mul_valid <= w_acc;
      if (w_acc) begin
        r_ptr    <= w_ptr_nxt;
        r_iss_id <= w_win;
        r_mul_a  <= bus.req_a[w_win*W +: W];
        r_mul_b  <= bus.req_b[w_win*W +: W];
        r_cnt    <= r_cnt + 16'd1;
      end
    end
  end

  // Only the valid bits need a reset. The ids are ignored while their valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) r_tag_v[0] <= 1'b0;
    else        r_tag_v[0] <= r_mul_valid;
    r_tag_id[0] <= r_iss_id;
    for (int unsigned s = 1; s < LAT; s++) begin
      if (!rst_n) r_tag_v[s] <= 1'b0;
      else        r_tag_v[s] <= r_tag_v[s-1];
      r_tag_id[s] <= r_tag_id[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else if (r_tag_v[LAT-1]) begin
      r_rsp_valid <= NREQ'(1) << r_tag_id[LAT-1];
      r_rsp_id    <= r_tag_id[LAT-1];
      r_rsp_data  <= bus.mul_p;
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.mul_valid = r_mul_valid;
  assign bus.mul_a     = r_mul_a;
  assign bus.mul_b     = r_mul_b;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.issue_cnt = r_cnt;
  assign bus.idle      = ~r_mul_valid & ~|r_tag_v & ~|r_rsp_valid;
endmodule
